// File: rtl/gray_code_generator.sv
// Free-running 3-bit Gray code source with programmable dwell, up/down stepping,
// load, start/stop, consumer back-pressure and a wrap pulse; all outputs registered.
module gray_code_generator #(
   parameter int HOLD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic       dir,
   input  logic       load,
   input  logic [2:0] load_val,
   input  logic       ready,
   output logic       w,
   output logic       x,
   output logic       y,
   output logic       valid,
   output logic       wrap
);

   localparam int DW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(HOLD_CYCLES - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t          state, state_nxt;
   logic [2:0]      bin, bin_nxt;
   logic [DW-1:0]   dwell, dwell_nxt;
   logic            wrap_nxt;
   logic [2:0]      gray_nxt;
   logic            valid_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         bin   <= 3'd0;
         dwell <= '0;
      end else begin
         state <= state_nxt;
         bin   <= bin_nxt;
         dwell <= dwell_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && !stop) state_nxt = RUN;
         RUN:     if (stop) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Dwell survives stop/start so a resumed run finishes the interrupted hold.
   always_comb begin
      bin_nxt   = bin;
      dwell_nxt = dwell;
      wrap_nxt  = 1'b0;
      if (load) begin
         bin_nxt   = load_val;
         dwell_nxt = '0;
      end else if (state == RUN && !stop && ready) begin
         if (dwell == DWELL_LAST) begin
            dwell_nxt = '0;
            if (dir) begin
               bin_nxt  = bin + 3'd1;
               wrap_nxt = (bin == 3'd7);
            end else begin
               bin_nxt  = bin - 3'd1;
               wrap_nxt = (bin == 3'd0);
            end
         end else begin
            dwell_nxt = dwell + DW'(1);
         end
      end
   end

   always_comb begin
      gray_nxt  = {bin_nxt[2], bin_nxt[2] ^ bin_nxt[1], bin_nxt[1] ^ bin_nxt[0]};
      valid_nxt = (state_nxt == RUN);
   end

   // Outputs register the next-state view so they track bin/state on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w     <= 1'b0;
         x     <= 1'b0;
         y     <= 1'b0;
         valid <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         {w, x, y} <= gray_nxt;
         valid     <= valid_nxt;
         wrap      <= wrap_nxt;
      end
   end

endmodule

// File: tb/tb_gray_code_generator.sv
// Directed bench for gray_code_generator (HOLD_CYCLES=4): reset, up/down runs,
// back-pressure, load override, start/stop resume, and async reset mid-run.
module tb_gray_code_generator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, stop, dir, load, ready;
   logic [2:0] load_val;
   logic       w, x, y, valid, wrap;

   int n_cmp = 0;
   int n_bad = 0;

   // Gray code indexed by binary count
   logic [2:0] gtab [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                            3'b110, 3'b111, 3'b101, 3'b100};

   gray_code_generator #(.HOLD_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir),
      .load(load), .load_val(load_val), .ready(ready),
      .w(w), .x(x), .y(y), .valid(valid), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [2:0] code,
                            input logic v, input logic wr);
      check({tag, ".code"},  {w, x, y}, code);
      check({tag, ".valid"}, {2'b00, valid}, {2'b00, v});
      check({tag, ".wrap"},  {2'b00, wrap}, {2'b00, wr});
   endtask

   initial begin
      rst_n = 1'b0; start = 0; stop = 0; dir = 1; load = 0; ready = 1; load_val = 3'd0;
      repeat (2) tick();
      check_out("reset", 3'b000, 1'b0, 1'b0);
      rst_n = 1'b1;
      repeat (2) tick();
      check_out("idle_after_reset", 3'b000, 1'b0, 1'b0);

      // start with stop: stop wins
      start = 1; stop = 1;
      tick();
      check_out("start_stop_idle", 3'b000, 1'b0, 1'b0);
      start = 0; stop = 0;
      tick();
      check_out("still_idle", 3'b000, 1'b0, 1'b0);

      // up count, 4 clocks per code, wrap on return to 000
      start = 1;
      tick();
      start = 0;
      for (int i = 0; i < 36; i++) begin
         check_out($sformatf("up%0d", i), gtab[(i / 4) % 8], 1'b1, (i == 32));
         if (i < 35) tick();
      end

      // load during the advance cycle overrides it: bin=2 -> 011
      load = 1; load_val = 3'd2;
      tick();
      load = 0;
      check_out("load_over_adv", 3'b011, 1'b1, 1'b0);
      tick(); tick();
      check_out("bp_pre", 3'b011, 1'b1, 1'b0);
      ready = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_out($sformatf("bp_hold%0d", i), 3'b011, 1'b1, 1'b0);
      end
      ready = 1;
      tick();
      check_out("bp_ret1", 3'b011, 1'b1, 1'b0);
      tick();
      check_out("bp_adv", 3'b010, 1'b1, 1'b0);

      // run on to 111 (bin 5) and sit in its last dwell cycle
      repeat (4) tick();
      check_out("to_110", 3'b110, 1'b1, 1'b0);
      repeat (4) tick();
      check_out("to_111", 3'b111, 1'b1, 1'b0);
      repeat (3) tick();
      check_out("111_last", 3'b111, 1'b1, 1'b0);
      load = 1; load_val = 3'b101;
      tick();
      load = 0;
      for (int i = 0; i < 4; i++) begin
         check_out($sformatf("load5_%0d", i), 3'b111, 1'b1, 1'b0);
         tick();
      end
      check_out("after_load5", 3'b101, 1'b1, 1'b0);

      // stop at dwell=1, then resume mid-dwell
      tick();
      stop = 1;
      tick();
      stop = 0;
      check_out("stopped", 3'b101, 1'b0, 1'b0);
      tick(); tick();
      check_out("stopped_frozen", 3'b101, 1'b0, 1'b0);
      start = 1;
      tick();
      start = 0;
      check_out("restart", 3'b101, 1'b1, 1'b0);
      tick();
      check_out("resume1", 3'b101, 1'b1, 1'b0);
      tick();
      check_out("resume2", 3'b101, 1'b1, 1'b0);
      tick();
      check_out("resume_adv", 3'b100, 1'b1, 1'b0);

      // async reset mid-run while showing 110
      load = 1; load_val = 3'd4;
      tick();
      load = 0;
      check_out("pre_rst_110", 3'b110, 1'b1, 1'b0);
      #1 rst_n = 1'b0;
      #1 check_out("async_rst", 3'b000, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
      repeat (2) tick();
      check_out("idle_after_rst2", 3'b000, 1'b0, 1'b0);

      // down count from reset: 000 -> 100 with wrap, then 101, 111, 110
      dir = 0; start = 1;
      tick();
      start = 0;
      for (int i = 0; i < 20; i++) begin
         check_out($sformatf("dn%0d", i), gtab[(8 - i / 4) % 8], 1'b1, (i == 4));
         if (i < 19) tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
